// File: rtl/crc32_frame_ctrl.sv
// crc32_frame_ctrl: frame-level CRC-32 engine (poly 0x04C11DB7, non-reflected,
// MSB-first). Folds up to four bytes per accepted word and holds one result
// until the consumer takes it.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_valid/s_ready       input word handshake
//   s_data[31:0]          frame word, byte [31:24] first on the wire
//   s_last, s_bytes[1:0]  last word flag and its valid byte count (0 means 4)
//   s_abort               drop the frame in progress
//   m_valid/m_ready       result handshake
//   m_crc[31:0]           final CRC (folded CRC ^ XOROUT)
//   frame_cnt[15:0]       delivered frame count, wraps
//   busy                  a frame is in progress or a result is pending
module crc32_frame_ctrl #(
  parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [1:0]  s_bytes,
  input  logic        s_abort,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_crc,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CRC_W-1:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] fold_c;
  logic [CRC_W-1:0] fold_base_c;
  logic [2:0]       nbytes_c;
  logic             accept_c;

  // Fold the first nbytes bytes of a word (MSB byte first) into a CRC.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] crc_in,
                                                input logic [31:0]      data,
                                                input logic [2:0]       nbytes);
    logic [CRC_W-1:0] c;
    logic [31:0]      d;
    c = crc_in;
    d = data;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) begin
        c = c ^ {d[31:24], 24'h0};
        for (int b = 0; b < int'(BYTE_W); b++) begin
          c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
        end
      end
      d = d << BYTE_W;
    end
    return c;
  endfunction

  assign accept_c    = s_valid & s_ready;
  assign nbytes_c    = (s_last && (s_bytes != 2'd0)) ? {1'b0, s_bytes} : 3'd4;
  // A new frame always starts from INIT, regardless of the register contents.
  assign fold_base_c = (state == IDLE) ? INIT : crc_q;
  assign fold_c      = crc_fold(fold_base_c, s_data, nbytes_c);

  // Next-state and CRC register update.
  always_comb begin
    next_state = state;
    crc_d      = crc_q;
    case (state)
      IDLE, RUN: begin
        if (s_abort) begin
          next_state = IDLE;
          crc_d      = INIT;
        end else if (accept_c) begin
          crc_d      = fold_c;
          next_state = s_last ? DONE : RUN;
        end
      end
      DONE: begin
        if (m_ready) begin
          next_state = IDLE;
          crc_d      = INIT;
        end
      end
      default: begin
        next_state = IDLE;
        crc_d      = INIT;
      end
    endcase
  end

  // State, CRC and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc_q     <= INIT;
      m_valid   <= 1'b0;
      m_crc     <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      state   <= next_state;
      crc_q   <= crc_d;
      m_valid <= (next_state == DONE);
      busy    <= (next_state != IDLE);
      s_ready <= (next_state != DONE);
      if ((state != DONE) && (next_state == DONE)) begin
        m_crc <= crc_d ^ XOROUT;
      end
      if ((state == DONE) && m_ready) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Testbench for crc32_frame_ctrl: known-answer frame table, directed corner
// sequences and random traffic against a transaction-level byte-queue model.
module tb_crc32_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_bytes;
  logic        s_abort;
  logic        m_ready;

  logic        s_ready,   s_ready_r;
  logic        m_valid,   m_valid_r;
  logic [31:0] m_crc,     m_crc_r;
  logic [15:0] frame_cnt, frame_cnt_r;
  logic        busy,      busy_r;

  crc32_frame_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_bytes(s_bytes), .s_abort(s_abort), .m_valid(m_valid),
    .m_ready(m_ready), .m_crc(m_crc), .frame_cnt(frame_cnt), .busy(busy)
  );

  crc32_frame_ctrl #(.XOROUT(32'h0000_0000)) dut_raw (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_r), .s_data(s_data),
    .s_last(s_last), .s_bytes(s_bytes), .s_abort(s_abort), .m_valid(m_valid_r),
    .m_ready(m_ready), .m_crc(m_crc_r), .frame_cnt(frame_cnt_r), .busy(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int              nw;
    logic [3:0][31:0] w;
    logic [1:0]      nb;
    logic [31:0]     exp_crc;
    logic [31:0]     exp_raw;
  } vec_t;

  int checks;
  int errors;

  // Reference model state: bytes of the open frame, pending result, count.
  bq_t         fbytes;
  bit          pending;
  bit          in_frame;
  logic [31:0] exp_raw;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC over a byte list, MSB first, no output XOR.
  function automatic logic [31:0] ref_crc(input bq_t q, input logic [31:0] init);
    logic [31:0] c;
    c = init;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (c[31] ^ q[i][b]) c = (c << 1) ^ 32'h04C1_1DB7;
        else                 c = c << 1;
      end
    end
    return c;
  endfunction

  function automatic bq_t frame_bytes(input vec_t v);
    bq_t         q;
    int          n;
    logic [31:0] t;
    for (int i = 0; i < v.nw; i++) begin
      n = (i == v.nw - 1 && v.nb != 2'd0) ? int'(v.nb) : 4;
      t = v.w[i];
      for (int k = 0; k < n; k++) begin
        q.push_back(t[31:24]);
        t = t << 8;
      end
    end
    return q;
  endfunction

  task automatic model_reset();
    fbytes.delete();
    pending  = 1'b0;
    in_frame = 1'b0;
    exp_cnt  = '0;
  endtask

  // One clock of the transaction model, applied to the inputs just driven.
  task automatic model_step(input logic v, input logic [31:0] d, input logic l,
                            input logic [1:0] nb, input logic ab, input logic mr);
    int          n;
    logic [31:0] t;
    if (pending) begin
      if (mr) begin
        pending = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
      end
    end else if (ab) begin
      fbytes.delete();
      in_frame = 1'b0;
    end else if (v) begin
      n = (l && nb != 2'd0) ? int'(nb) : 4;
      t = d;
      for (int k = 0; k < n; k++) begin
        fbytes.push_back(t[31:24]);
        t = t << 8;
      end
      if (l) begin
        exp_raw  = ref_crc(fbytes, 32'hFFFF_FFFF);
        fbytes.delete();
        pending  = 1'b1;
        in_frame = 1'b0;
      end else begin
        in_frame = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("m_valid",       32'(m_valid),     32'(pending));
    chk("s_ready",       32'(s_ready),     32'(!pending));
    chk("busy",          32'(busy),        32'(pending | in_frame));
    chk("frame_cnt",     32'(frame_cnt),   32'(exp_cnt));
    chk("m_valid_raw",   32'(m_valid_r),   32'(pending));
    chk("s_ready_raw",   32'(s_ready_r),   32'(!pending));
    chk("busy_raw",      32'(busy_r),      32'(pending | in_frame));
    chk("frame_cnt_raw", 32'(frame_cnt_r), 32'(exp_cnt));
    if (pending) begin
      chk("m_crc",     m_crc,   exp_raw ^ 32'hFFFF_FFFF);
      chk("m_crc_raw", m_crc_r, exp_raw);
    end
  endtask

  // Called at a falling edge: check, drive, clock, update model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                       input logic [1:0] nb, input logic ab, input logic mr);
    check_outputs();
    s_valid = v;
    s_data  = d;
    s_last  = l;
    s_bytes = nb;
    s_abort = ab;
    m_ready = mr;
    @(posedge clk);
    model_step(v, d, l, nb, ab, mr);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, 2'd0, 1'b0, mr);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_bytes = 2'd0;
    s_abort = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    chk("rst_m_valid",   32'(m_valid),   32'd0);
    chk("rst_m_crc",     m_crc,          32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("s_ready_after_rst", 32'(s_ready), 32'd1);
  endtask

  // Present each word until the model says it was taken; report first-word tries.
  task automatic send_frame(input vec_t v, input logic mr, output int first_tries);
    bit          acc;
    int          tries;
    logic        l;
    logic [1:0]  nb;
    first_tries = 0;
    for (int i = 0; i < v.nw; i++) begin
      l     = (i == v.nw - 1);
      nb    = l ? v.nb : 2'($urandom);
      tries = 0;
      do begin
        acc = !pending;
        cycle(1'b1, v.w[i], l, nb, 1'b0, mr);
        tries++;
      end while (!acc && tries < 20);
      chk("send_accept", 32'(acc), 32'd1);
      if (i == 0) first_tries = tries;
    end
  endtask

  vec_t tbl[7];
  vec_t abc;
  int   tries;
  bq_t  q;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_bytes = 2'd0; s_abort = 1'b0; m_ready = 1'b0;
    model_reset();

    // "123456789" with various fillers in excluded bytes, plus model-filled frames.
    tbl[0] = '{3, {32'h0, 32'h39AA_AAAA, 32'h3536_3738, 32'h3132_3334}, 2'd1, 32'hFC89_1918, 32'h0376_E6E7};
    tbl[1] = '{3, {32'h0, 32'h395A_C30F, 32'h3536_3738, 32'h3132_3334}, 2'd1, 32'hFC89_1918, 32'h0376_E6E7};
    tbl[2] = '{3, {32'h0, 32'h3900_0000, 32'h3536_3738, 32'h3132_3334}, 2'd1, 32'hFC89_1918, 32'h0376_E6E7};
    tbl[3] = '{1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 2'd0, 32'h0, 32'h0};
    tbl[4] = '{1, {32'h0, 32'h0, 32'h0, 32'hA577_1234}, 2'd1, 32'h0, 32'h0};
    tbl[5] = '{2, {32'h0, 32'h0, 32'h0506_FFFF, 32'h0102_0304}, 2'd2, 32'h0, 32'h0};
    tbl[6] = '{4, {32'hC0FF_EE99, 32'h1357_9BDF, 32'h8000_0001, 32'h0F1E_2D3C}, 2'd3, 32'h0, 32'h0};
    for (int i = 3; i < 7; i++) begin
      q = frame_bytes(tbl[i]);
      tbl[i].exp_raw = ref_crc(q, 32'hFFFF_FFFF);
      tbl[i].exp_crc = tbl[i].exp_raw ^ 32'hFFFF_FFFF;
    end

    // Table: each frame with m_ready=1; result is valid one cycle after last word.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i], 1'b1, tries);
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("tbl%0d_m_crc", i), m_crc, tbl[i].exp_crc);
      chk($sformatf("tbl%0d_m_crc_raw", i), m_crc_r, tbl[i].exp_raw);
      idle(1, 1'b1);
      chk($sformatf("tbl%0d_frame_cnt", i), 32'(frame_cnt), 32'(i + 1));
      idle(1, 1'b1);
    end

    // Result held under backpressure; words and abort during DONE are ignored.
    do_reset();
    send_frame(tbl[0], 1'b0, tries);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b1, 2'd0, (i == 2), 1'b0);
    chk("hold_m_crc", m_crc, 32'hFC89_1918);
    chk("hold_s_ready", 32'(s_ready), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("hold_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_m_valid", 32'(m_valid), 32'd0);

    // Back-to-back frames with s_valid held high: one rejected presentation.
    do_reset();
    send_frame(tbl[0], 1'b1, tries);
    send_frame(tbl[1], 1'b1, tries);
    chk("b2b_first_tries", 32'(tries), 32'd2);
    chk("b2b_m_crc", m_crc, 32'hFC89_1918);
    idle(2, 1'b1);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd2);

    // Abort on the second word, then a clean frame.
    do_reset();
    cycle(1'b1, 32'h3132_3334, 1'b0, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 32'h3536_3738, 1'b1, 2'd0, 1'b1, 1'b1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    send_frame(tbl[0], 1'b1, tries);
    chk("abort_m_crc", m_crc, 32'hFC89_1918);
    idle(2, 1'b1);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd1);

    // Reset pulsed mid-frame, then a clean frame.
    do_reset();
    cycle(1'b1, 32'h3132_3334, 1'b0, 2'd0, 1'b0, 1'b1);
    do_reset();
    send_frame(tbl[0], 1'b1, tries);
    chk("rstmid_m_crc", m_crc, 32'hFC89_1918);
    idle(2, 1'b1);
    chk("rstmid_frame_cnt", 32'(frame_cnt), 32'd1);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) == 0),
            2'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
    end
    idle(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
